// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and decode helper for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] PC_INC      = 16'd2;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] inst);
    return inst[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface fetch_unit_if;

  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_stall,
    input  imem_done,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_stall,
    output imem_done,
    output imem_data
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// 16-bit program counter with a redirect load port (priority) and a +2 increment port.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_pc,
  input  logic        inc,
  output logic [15:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage front end: issues imem reads from the PC, buffers the returned instruction
// and hands it to the IF/ID latch, handling downstream stalls, redirects and HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall_in,
  input  logic                redirect_in,
  input  logic [15:0]         redirect_pc,
  output logic [15:0]         inst_out,
  output logic [15:0]         pc_out,
  output logic                inst_valid,
  output logic                if_id_en,
  output logic                flush_out,
  output logic                imem_stall_out
);

  fetch_state_t state, next_state;
  logic         drop, next_drop;
  logic [15:0]  inst_buf, next_buf;
  logic [15:0]  pc, pc_plus2, addr;
  logic         pc_load, pc_inc, rd_req;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign pc_plus2 = pc + PC_INC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= REQ;
      drop     <= 1'b0;
      inst_buf <= NOP_INSTR;
    end else begin
      state    <= next_state;
      drop     <= next_drop;
      inst_buf <= next_buf;
    end
  end

  // A redirect in WAIT cannot abort the outstanding read, so it is marked for discard
  // unless its data returns in this very cycle.
  always_comb begin
    next_state = state;
    next_drop  = drop;
    next_buf   = inst_buf;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    rd_req     = 1'b0;
    addr       = pc;

    if (redirect_in) begin
      pc_load = 1'b1;
      if (state == WAIT && !imem.imem_done) begin
        next_drop = 1'b1;
      end else begin
        next_state = REQ;
        next_drop  = 1'b0;
        next_buf   = NOP_INSTR;
      end
    end else begin
      case (state)
        REQ: begin
          rd_req = 1'b1;
          if (!imem.imem_stall) begin
            next_state = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_done) begin
            if (drop) begin
              next_drop  = 1'b0;
              next_state = REQ;
            end else begin
              next_buf   = imem.imem_data;
              next_state = VALID;
            end
          end
        end
        VALID: begin
          // The next fetch is issued in the transfer cycle to keep the 2-cycle cadence.
          if (!stall_in) begin
            if (is_halt(inst_buf)) begin
              next_state = HALTED;
            end else begin
              pc_inc     = 1'b1;
              rd_req     = 1'b1;
              addr       = pc_plus2;
              next_state = imem.imem_stall ? REQ : WAIT;
            end
          end
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = REQ;
        end
      endcase
    end
  end

  assign imem.imem_rd   = rd_req & rst;
  assign imem.imem_addr = addr;

  assign inst_valid     = (state == VALID);
  assign inst_out       = inst_valid ? inst_buf : NOP_INSTR;
  assign pc_out         = pc_plus2;
  assign if_id_en       = ~stall_in | redirect_in;
  assign flush_out      = redirect_in;
  assign imem_stall_out = ~inst_valid;

endmodule
